// File: rtl/aux_cnt_seq.sv
// rtl/aux_cnt_seq.sv - count sequencer around an external shared 6-bit +1 incrementer.
// Ticks every DIV enabled cycles; start/done handshake with pause and abort.
module aux_cnt_seq #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [5:0] limit_i,
  input  logic       en_i,
  input  logic       pause_i,
  input  logic       abort_i,
  output logic [5:0] inc_op_o,
  input  logic [5:0] inc_res_i,
  output logic [5:0] cnt_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [5:0] DIV_M1 = 6'(DIV - 1);

  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] limit_q, limit_d;
  logic [5:0] presc_q, presc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    presc_d = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_d   = '0;
          presc_d = '0;
          if (limit_i != 6'd0) begin
            limit_d = limit_i;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end else if (pause_i) begin
          state_d = ST_PAUSE;
        end else if (en_i) begin
          if (presc_q == DIV_M1) begin
            // Termination needs an exact match, so a faulty incrementer keeps it running.
            cnt_d   = inc_res_i;
            presc_d = '0;
            if (inc_res_i == limit_q) state_d = ST_DONE;
          end else begin
            presc_d = presc_q + 6'd1;
          end
        end
      end
      ST_PAUSE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end else if (!pause_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flags decode the next state so they move on the same edge as state_o.
  assign busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inc_op_o = cnt_q;
  assign cnt_o    = cnt_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_aux_cnt_seq.sv
// tb/tb_aux_cnt_seq.sv - directed bench for aux_cnt_seq with DIV=1 and DIV=3 instances.
module tb_aux_cnt_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s1 = 0, en1 = 1, pa1 = 0, ab1 = 0, bad_inc = 0;
  logic [5:0] lim1 = 0;
  logic [5:0] op1, res1, cnt1;
  logic       busy1, done1;
  logic [1:0] st1;

  logic       s3 = 0, en3 = 0, pa3 = 0, ab3 = 0;
  logic [5:0] lim3 = 0;
  logic [5:0] op3, res3, cnt3;
  logic       busy3, done3;
  logic [1:0] st3;

  assign res1 = bad_inc ? op1 + 6'd2 : op1 + 6'd1;
  assign res3 = op3 + 6'd1;

  aux_cnt_seq #(.DIV(1)) u1 (
    .clk(clk), .rst(rst), .start_i(s1), .limit_i(lim1), .en_i(en1),
    .pause_i(pa1), .abort_i(ab1), .inc_op_o(op1), .inc_res_i(res1),
    .cnt_o(cnt1), .busy_o(busy1), .done_o(done1), .state_o(st1)
  );

  aux_cnt_seq #(.DIV(3)) u3 (
    .clk(clk), .rst(rst), .start_i(s3), .limit_i(lim3), .en_i(en3),
    .pause_i(pa3), .abort_i(ab3), .inc_op_o(op3), .inc_res_i(res3),
    .cnt_o(cnt3), .busy_o(busy3), .done_o(done3), .state_o(st3)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input int st, input int cnt, input int busy, input int done);
    chk({tag, " state"}, int'(st1), st);
    chk({tag, " cnt"}, int'(cnt1), cnt);
    chk({tag, " busy"}, int'(busy1), busy);
    chk({tag, " done"}, int'(done1), done);
  endtask

  int exp3 [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 2};
  logic en_pat [9] = '{1, 0, 1, 1, 0, 1, 1, 0, 1};

  initial begin
    step();
    step();
    rst = 1'b0;
    chk1("reset", 0, 0, 0, 0);
    chk("reset op", int'(op1), 0);

    // Reset mid-count at cnt=5.
    s1 = 1; lim1 = 6'd10;
    step();
    s1 = 0;
    repeat (5) step();
    chk1("run5", 1, 5, 1, 0);
    #3 rst = 1'b1;
    #1;
    chk1("async rst", 0, 0, 0, 0);
    step();
    rst = 1'b0;
    repeat (10) step();
    chk1("idle hold", 0, 0, 0, 0);

    // Basic count to 4.
    s1 = 1; lim1 = 6'd4;
    step();
    s1 = 0;
    chk1("start4", 1, 0, 1, 0);
    for (int n = 1; n <= 4; n++) begin
      step();
      if (n < 4) chk1("cnt4 run", 1, n, 1, 0);
      else       chk1("cnt4 done", 3, 4, 0, 1);
    end
    step();
    chk1("cnt4 idle", 0, 4, 0, 0);

    // Pause for 5 cycles at cnt=3.
    s1 = 1; lim1 = 6'd10;
    step();
    s1 = 0;
    repeat (3) step();
    chk1("pre pause", 1, 3, 1, 0);
    pa1 = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("paused", 2, 3, 1, 0);
    end
    pa1 = 0;
    step();
    chk1("resume", 1, 3, 1, 0);
    step();
    chk1("resume tick", 1, 4, 1, 0);
    repeat (6) step();
    chk1("done10", 3, 10, 0, 1);
    step();
    chk1("idle10", 0, 10, 0, 0);

    // Abort beats pause at cnt=6.
    s1 = 1; lim1 = 6'd10;
    step();
    s1 = 0;
    repeat (6) step();
    chk("pre abort cnt", int'(cnt1), 6);
    pa1 = 1; ab1 = 1;
    step();
    chk1("abort", 0, 0, 0, 0);
    pa1 = 0; ab1 = 0;
    step();
    chk1("abort idle", 0, 0, 0, 0);

    // Zero limit goes straight to DONE.
    s1 = 1; lim1 = 6'd0;
    step();
    s1 = 0;
    chk1("lim0 done", 3, 0, 0, 1);
    step();
    chk1("lim0 idle", 0, 0, 0, 0);

    // Start held high through RUN is ignored.
    s1 = 1; lim1 = 6'd3;
    step();
    for (int n = 1; n <= 3; n++) begin
      step();
      chk("held start cnt", int'(cnt1), n);
    end
    chk1("held start done", 3, 3, 0, 1);
    s1 = 0;
    step();
    chk1("held start idle", 0, 3, 0, 0);

    // Full range to 63 without wrap.
    s1 = 1; lim1 = 6'd63;
    step();
    s1 = 0;
    repeat (62) step();
    chk1("cnt62", 1, 62, 1, 0);
    step();
    chk1("cnt63", 3, 63, 0, 1);
    step();
    chk1("cnt63 idle", 0, 63, 0, 0);

    // Faulty incrementer (+2) never matches an odd limit.
    bad_inc = 1;
    s1 = 1; lim1 = 6'd5;
    step();
    s1 = 0;
    step(); chk("bad inc 2", int'(cnt1), 2);
    step(); chk("bad inc 4", int'(cnt1), 4);
    step(); chk1("bad inc 6", 1, 6, 1, 0);
    repeat (40) step();
    chk1("bad inc stuck", 1, 6'(6 + 80), 1, 0);
    ab1 = 1;
    step();
    chk1("bad inc abort", 0, 0, 0, 0);
    ab1 = 0; bad_inc = 0;

    // DIV=3 with gapped enable.
    s3 = 1; lim3 = 6'd2;
    step();
    s3 = 0;
    chk("div3 start state", int'(st3), 1);
    for (int i = 0; i < 9; i++) begin
      en3 = en_pat[i];
      step();
      chk("div3 cnt", int'(cnt3), exp3[i]);
      chk("div3 done", int'(done3), (i == 8) ? 1 : 0);
    end
    chk("div3 state done", int'(st3), 3);
    en3 = 0;
    step();
    chk("div3 idle", int'(st3), 0);
    chk("div3 idle cnt", int'(cnt3), 2);
    chk("div3 idle done", int'(done3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
